mips_ctrl_fsm: RTL and testbench

MIPS_CTRL_FSM -- requirements
Module: mips_ctrl_fsm

---
 rtl/mips_ctrl_fsm.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_mips_ctrl_fsm.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_ctrl_fsm.sv
// mips_ctrl_fsm -- multicycle MIPS-subset control unit.
// Sequences FETCH/DECODE/execute/write-back for ADD, SUB, SLT, JR, XORI,
// LW, SW, BNE, J and JAL; any other encoding parks the FSM in TRAP with a
// sticky illegal flag until reset.
// Optional feature: define MIPS_CTRL_RETIRE_CNT_EN to add a 32-bit
// retired-instruction counter on output retired_count.
// Control outputs are decoded from the state register and, where the
// datapath needs same-cycle reaction (mem_ready, zero), from the inputs.
// All outputs are forced low while reset is high.
module mips_ctrl_fsm (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        iord,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic        reg_we,
   output logic [1:0]  reg_dst,
   output logic [1:0]  wb_src,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alu_op,
   output logic        instr_done,
   output logic        illegal
`ifdef MIPS_CTRL_RETIRE_CNT_EN
   ,
   output logic [31:0] retired_count
`endif
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      EXEC_I   = 4'd3,
      WB_R     = 4'd4,
      WB_I     = 4'd5,
      MEM_ADDR = 4'd6,
      MEM_RD   = 4'd7,
      WB_MEM   = 4'd8,
      MEM_WR   = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11,
      JREG     = 4'd12,
      TRAP     = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_XOR  = 3'd2;
   localparam logic [2:0] ALU_SLT  = 3'd3;

   state_t state_r;
   state_t next_state_s;
   logic   illegal_r;

   // ALU operation selected by an R-type funct field.
   function automatic logic [2:0] r_alu_op(input logic [5:0] fn);
      logic [2:0] op;
      case (fn)
         FN_ADD:  op = ALU_ADD;
         FN_SUB:  op = ALU_SUB;
         FN_SLT:  op = ALU_SLT;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   // State register; reset returns to FETCH immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= FETCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic: memory states wait on mem_ready, DECODE dispatches.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         FETCH: begin
            if (mem_ready) next_state_s = DECODE;
            else           next_state_s = FETCH;
         end
         DECODE: begin
            case (opcode)
               OP_RTYPE: begin
                  case (funct)
                     FN_ADD, FN_SUB, FN_SLT: next_state_s = EXEC_R;
                     FN_JR:                  next_state_s = JREG;
                     default:                next_state_s = TRAP;
                  endcase
               end
               OP_XORI:       next_state_s = EXEC_I;
               OP_LW, OP_SW:  next_state_s = MEM_ADDR;
               OP_BNE:        next_state_s = BRANCH;
               OP_J, OP_JAL:  next_state_s = JUMP;
               default:       next_state_s = TRAP;
            endcase
         end
         EXEC_R:   next_state_s = WB_R;
         EXEC_I:   next_state_s = WB_I;
         WB_R:     next_state_s = FETCH;
         WB_I:     next_state_s = FETCH;
         MEM_ADDR: begin
            if (opcode == OP_SW) next_state_s = MEM_WR;
            else                 next_state_s = MEM_RD;
         end
         MEM_RD: begin
            if (mem_ready) next_state_s = WB_MEM;
            else           next_state_s = MEM_RD;
         end
         WB_MEM:   next_state_s = FETCH;
         MEM_WR: begin
            if (mem_ready) next_state_s = FETCH;
            else           next_state_s = MEM_WR;
         end
         BRANCH:   next_state_s = FETCH;
         JUMP:     next_state_s = FETCH;
         JREG:     next_state_s = FETCH;
         TRAP:     next_state_s = TRAP;
         default:  next_state_s = FETCH;
      endcase
   end

   // Output decode; everything defaults low and stays low during reset.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 2'd0;
      reg_we     = 1'b0;
      reg_dst    = 2'd0;
      wb_src     = 2'd0;
      alu_src_b  = 2'd0;
      alu_op     = 3'd0;
      instr_done = 1'b0;
      if (reset) begin
         mem_req = 1'b0;
      end else begin
         case (state_r)
            FETCH: begin
               mem_req = 1'b1;
               iord    = 1'b0;
               ir_we   = mem_ready;
               pc_we   = mem_ready;
               pc_src  = 2'd0;
            end
            DECODE: begin
               mem_req = 1'b0;
            end
            EXEC_R: begin
               alu_src_b = 2'd0;
               alu_op    = r_alu_op(funct);
            end
            WB_R: begin
               alu_op     = r_alu_op(funct);
               reg_we     = 1'b1;
               reg_dst    = 2'd1;
               wb_src     = 2'd0;
               instr_done = 1'b1;
            end
            EXEC_I: begin
               alu_src_b = 2'd2;
               alu_op    = ALU_XOR;
            end
            WB_I: begin
               alu_src_b  = 2'd2;
               alu_op     = ALU_XOR;
               reg_we     = 1'b1;
               reg_dst    = 2'd0;
               wb_src     = 2'd0;
               instr_done = 1'b1;
            end
            MEM_ADDR: begin
               alu_src_b = 2'd1;
               alu_op    = ALU_ADD;
            end
            MEM_RD: begin
               mem_req   = 1'b1;
               iord      = 1'b1;
               alu_src_b = 2'd1;
               alu_op    = ALU_ADD;
            end
            WB_MEM: begin
               reg_we     = 1'b1;
               reg_dst    = 2'd0;
               wb_src     = 2'd1;
               instr_done = 1'b1;
            end
            MEM_WR: begin
               mem_req    = 1'b1;
               mem_we     = 1'b1;
               iord       = 1'b1;
               alu_src_b  = 2'd1;
               alu_op     = ALU_ADD;
               instr_done = mem_ready;
            end
            BRANCH: begin
               alu_src_b  = 2'd0;
               alu_op     = ALU_SUB;
               instr_done = 1'b1;
               if (!zero) begin
                  pc_we  = 1'b1;
                  pc_src = 2'd1;
               end else begin
                  pc_we  = 1'b0;
               end
            end
            JUMP: begin
               pc_we      = 1'b1;
               pc_src     = 2'd2;
               instr_done = 1'b1;
               if (opcode == OP_JAL) begin
                  reg_we  = 1'b1;
                  reg_dst = 2'd2;
                  wb_src  = 2'd2;
               end else begin
                  reg_we  = 1'b0;
               end
            end
            JREG: begin
               pc_we      = 1'b1;
               pc_src     = 2'd3;
               instr_done = 1'b1;
            end
            TRAP: begin
               mem_req = 1'b0;
            end
            default: begin
               mem_req = 1'b0;
            end
         endcase
      end
   end

   // Sticky illegal flag, raised on entry to TRAP and cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         illegal_r <= 1'b0;
      end else if (next_state_s == TRAP) begin
         illegal_r <= 1'b1;
      end else begin
         illegal_r <= illegal_r;
      end
   end

   assign illegal = illegal_r;

`ifdef MIPS_CTRL_RETIRE_CNT_EN
   logic [31:0] retired_count_r;

   // Retirement counter; wraps naturally at 2^32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retired_count_r <= 32'd0;
      end else if (instr_done) begin
         retired_count_r <= retired_count_r + 32'd1;
      end else begin
         retired_count_r <= retired_count_r;
      end
   end

   assign retired_count = retired_count_r;
`endif

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// tb_mips_ctrl_fsm -- randomized self-checking bench for mips_ctrl_fsm.
// The reference describes each instruction class as an ordered list of
// steps (fetch, decode, class-specific steps) and derives the expected
// control word of each step from the instruction-set rules. The bench also
// plays the instruction register: opcode/funct change after a completed fetch.
module tb_mips_ctrl_fsm;

   logic        clk;
   logic        reset;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        mem_ready;
   logic        mem_req, mem_we, iord, ir_we, pc_we, reg_we, instr_done, illegal;
   logic [1:0]  pc_src, reg_dst, wb_src, alu_src_b;
   logic [2:0]  alu_op;
`ifdef MIPS_CTRL_RETIRE_CNT_EN
   logic [31:0] retired_count;
`endif

   mips_ctrl_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
      .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
      .wb_src(wb_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .instr_done(instr_done), .illegal(illegal)
`ifdef MIPS_CTRL_RETIRE_CNT_EN
      , .retired_count(retired_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       mem_req, mem_we, iord, ir_we, pc_we;
      logic [1:0] pc_src;
      logic       reg_we;
      logic [1:0] reg_dst, wb_src, alu_src_b;
      logic [2:0] alu_op;
      logic       instr_done, illegal;
   } outs_t;

   outs_t act;
   assign act = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
                 wb_src, alu_src_b, alu_op, instr_done, illegal};

   localparam int C_R = 0, C_XORI = 1, C_LW = 2, C_SW = 3, C_BNE = 4,
                  C_J = 5, C_JAL = 6, C_JR = 7, C_ILL = 8;

   int          checks = 0;
   int          errors = 0;
   int          cur_cls, cur_idx, cur_cyc;
   logic [5:0]  cur_op, cur_fn;
   logic        cur_retired;
   int          act_done_cyc, act_ill_cyc, act_memio_cnt, act_req_after_fetch;
   logic [31:0] exp_retired;

   // Instruction class from the ISA table.
   function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) return C_R;
      if (op == 6'h00 && fn == 6'h08) return C_JR;
      if (op == 6'h0E) return C_XORI;
      if (op == 6'h23) return C_LW;
      if (op == 6'h2B) return C_SW;
      if (op == 6'h05) return C_BNE;
      if (op == 6'h02) return C_J;
      if (op == 6'h03) return C_JAL;
      return C_ILL;
   endfunction

   function automatic int nsteps(input int cls);
      if (cls == C_R || cls == C_XORI || cls == C_SW) return 4;
      if (cls == C_LW) return 5;
      return 3;
   endfunction

   // Expected control word for a given step of an instruction.
   function automatic outs_t model_out(input int cls, input int idx, input logic [5:0] fn,
                                       input logic rdy, input logic z);
      outs_t o;
      o = '0;
      if (idx == 0) begin
         o.mem_req = 1'b1;
         o.ir_we   = rdy;
         o.pc_we   = rdy;
      end else if (idx >= 2) begin
         case (cls)
            C_R: begin
               o.alu_op = (fn == 6'h22) ? 3'd1 : ((fn == 6'h2A) ? 3'd3 : 3'd0);
               if (idx == 3) begin
                  o.reg_we = 1'b1; o.reg_dst = 2'd1; o.instr_done = 1'b1;
               end
            end
            C_XORI: begin
               o.alu_src_b = 2'd2; o.alu_op = 3'd2;
               if (idx == 3) begin o.reg_we = 1'b1; o.instr_done = 1'b1; end
            end
            C_LW: begin
               if (idx == 4) begin
                  o.reg_we = 1'b1; o.wb_src = 2'd1; o.instr_done = 1'b1;
               end else begin
                  o.alu_src_b = 2'd1;
                  if (idx == 3) begin o.mem_req = 1'b1; o.iord = 1'b1; end
               end
            end
            C_SW: begin
               o.alu_src_b = 2'd1;
               if (idx == 3) begin
                  o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = 1'b1; o.instr_done = rdy;
               end
            end
            C_BNE: begin
               o.alu_op = 3'd1; o.instr_done = 1'b1;
               if (!z) begin o.pc_we = 1'b1; o.pc_src = 2'd1; end
            end
            C_J, C_JAL: begin
               o.pc_we = 1'b1; o.pc_src = 2'd2; o.instr_done = 1'b1;
               if (cls == C_JAL) begin o.reg_we = 1'b1; o.reg_dst = 2'd2; o.wb_src = 2'd2; end
            end
            C_JR: begin o.pc_we = 1'b1; o.pc_src = 2'd3; o.instr_done = 1'b1; end
            default: o.illegal = 1'b1;
         endcase
      end
      return o;
   endfunction

   task automatic check_outs(input string name, input outs_t a, input outs_t e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s op=%h fn=%h step=%0d cyc=%0d got=%05h exp=%05h",
                  name, cur_op, cur_fn, cur_idx, cur_cyc, a, e);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   function automatic logic is_mem_step();
      return (cur_idx == 0) || ((cur_cls == C_LW || cur_cls == C_SW) && cur_idx == 3);
   endfunction

   task automatic start_instr(input logic [5:0] op, input logic [5:0] fn);
      cur_op = op; cur_fn = fn; cur_cls = cls_of(op, fn);
      cur_idx = 0; cur_cyc = 1; cur_retired = 1'b0;
      act_done_cyc = 0; act_ill_cyc = 0; act_memio_cnt = 0; act_req_after_fetch = 0;
   endtask

   // One clock cycle: drive inputs, compare, then advance the reference.
   // Entered and left at a falling edge.
   task automatic cycle(input logic rdy, input logic z);
      outs_t e;
      mem_ready = rdy;
      zero      = z;
      #1;
      e = model_out(cur_cls, cur_idx, cur_fn, rdy, z);
      check_outs("ctrl", act, e);
`ifdef MIPS_CTRL_RETIRE_CNT_EN
      check_val("retired_count", retired_count, exp_retired);
`endif
      if (instr_done && act_done_cyc == 0) act_done_cyc = cur_cyc;
      if (illegal && act_ill_cyc == 0) act_ill_cyc = cur_cyc;
      if (mem_req && iord) act_memio_cnt++;
      if (mem_req && cur_cyc > 1) act_req_after_fetch++;
      @(posedge clk);
      #1;
      if (e.instr_done) exp_retired = exp_retired + 32'd1;
      if (!(is_mem_step() && !rdy)) begin
         if (cur_idx == 0) begin
            opcode = cur_op;
            funct  = cur_fn;
         end
         if (!(cur_cls == C_ILL && cur_idx >= 2)) cur_idx++;
         if (cur_cls != C_ILL && cur_idx == nsteps(cur_cls)) cur_retired = 1'b1;
      end
      cur_cyc++;
      @(negedge clk);
   endtask

   // Run one legal instruction to retirement. waits < 0: fully random
   // mem_ready; otherwise fetch is zero-wait and the data access waits
   // 'waits' cycles while mem_ready is random (ignored) elsewhere.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int waits, input logic z);
      int   wait_cnt;
      int   budget;
      logic rdy;
      wait_cnt = 0;
      budget   = 0;
      start_instr(op, fn);
      while (!cur_retired && budget < 200) begin
         if (waits < 0) rdy = ($urandom_range(0, 99) < 60);
         else if (cur_idx == 0) rdy = 1'b1;
         else if (is_mem_step()) begin
            rdy = (wait_cnt >= waits);
            wait_cnt++;
         end else rdy = 1'($urandom_range(0, 1));
         cycle(rdy, z);
         budget++;
      end
      check_val("retire_within_budget", {31'd0, cur_retired}, 32'd1);
   endtask

   task automatic run_illegal(input logic [5:0] op, input logic [5:0] fn, input int n);
      start_instr(op, fn);
      cycle(1'b1, 1'b0);
      for (int i = 1; i < n; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   // Assert reset at a falling edge with mem_ready high; everything must be low.
   task automatic do_reset();
      outs_t z_o;
      z_o = '0;
      mem_ready = 1'b1;
      reset     = 1'b1;
      #1;
      check_outs("reset_async", act, z_o);
      @(posedge clk);
      #1;
      check_outs("reset_hold", act, z_o);
`ifdef MIPS_CTRL_RETIRE_CNT_EN
      check_val("reset_retired", retired_count, 32'd0);
`endif
      @(negedge clk);
      mem_ready   = 1'b0;
      reset       = 1'b0;
      exp_retired = 32'd0;
   endtask

   logic [5:0] leg_op [10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0E, 6'h23, 6'h2B, 6'h05, 6'h02, 6'h03};
   logic [5:0] leg_fn [10] = '{6'h20, 6'h22, 6'h2A, 6'h08, 6'h11, 6'h05, 6'h3C, 6'h00, 6'h12, 6'h07};
   logic [5:0] ill_op [4]  = '{6'h3F, 6'h04, 6'h08, 6'h00};
   logic [5:0] ill_fn [4]  = '{6'h00, 6'h00, 6'h01, 6'h21};

   initial begin
      outs_t z_o;
      int    k;
      z_o = '0;
      reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 6'h00; funct = 6'h00;
      exp_retired = 32'd0;
      start_instr(6'h00, 6'h20);
      @(negedge clk);
      do_reset();

      // Directed cases with literal latency pins.
      run_instr(6'h00, 6'h20, 0, 1'b0);
      check_val("add_latency", act_done_cyc, 4);
      run_instr(6'h23, 6'h00, 2, 1'b0);
      check_val("lw_wait2_latency", act_done_cyc, 7);
      check_val("lw_memio_cycles", act_memio_cnt, 3);
      run_instr(6'h2B, 6'h00, 0, 1'b0);
      check_val("sw_latency", act_done_cyc, 4);
      run_instr(6'h05, 6'h00, 0, 1'b0);
      check_val("bne_taken_latency", act_done_cyc, 3);
      run_instr(6'h05, 6'h00, 0, 1'b1);
      check_val("bne_not_taken_latency", act_done_cyc, 3);
      run_instr(6'h03, 6'h00, 0, 1'b0);
      check_val("jal_latency", act_done_cyc, 3);
      run_instr(6'h00, 6'h08, 0, 1'b0);
      check_val("jr_latency", act_done_cyc, 3);
      run_instr(6'h0E, 6'h00, 0, 1'b0);
      check_val("xori_latency", act_done_cyc, 4);

      // Illegal opcode: trap from cycle 3, no requests for 20 more cycles.
      run_illegal(6'h3F, 6'h00, 23);
      check_val("illegal_first_cycle", act_ill_cyc, 3);
      check_val("trap_mem_req_cycles", act_req_after_fetch, 0);
      do_reset();
      check_val("illegal_cleared", {31'd0, illegal}, 32'd0);

      // Reset in the middle of a stalled store.
      start_instr(6'h2B, 6'h00);
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      mem_ready = 1'b0;
      #2;
      check_val("sw_req_before_reset", {31'd0, mem_req}, 32'd1);
      reset = 1'b1;
      #1;
      check_outs("reset_mid_mem_wr", act, z_o);
`ifdef MIPS_CTRL_RETIRE_CNT_EN
      check_val("reset_mid_mem_wr_retired", retired_count, 32'd0);
`endif
      @(negedge clk);
      #1;
      check_outs("reset_mid_mem_wr_hold", act, z_o);
      reset = 1'b0;
      exp_retired = 32'd0;
      run_instr(6'h00, 6'h22, 1, 1'b0);
      check_val("sub_after_reset_latency", act_done_cyc, 4);

      // Randomized instruction stream with random memory timing.
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 11) == 0) begin
            k = $urandom_range(0, 3);
            run_illegal(ill_op[k], ill_fn[k], 6);
            do_reset();
         end else begin
            k = $urandom_range(0, 9);
            run_instr(leg_op[k], leg_fn[k], -1, 1'($urandom_range(0, 1)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
